// File: rtl/sensor_scan_ctrl_pkg.sv
// Shared types and constants for the baggage-height sensor scan controller.
package sensor_scan_pkg;

    // Number of height sensors polled per scan.
    localparam int NUM_SENSORS  = 4;
    // Default width of one sensor reading and of the reduced height.
    localparam int DEF_SENSOR_W = 8;
    // Width of the rounding sums (four 8-bit readings plus rounding bias).
    localparam int SUM_W        = 10;
    // Width of the sensor select.
    localparam int SEL_W        = 2;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/sensor_scan_ctrl_if.sv
// Sample bus towards the sensors plus the result handshake towards the
// baggage-drop logic. The controller is the master on both.
interface sensor_scan_ctrl_if
    import sensor_scan_pkg::*;
#(
    parameter int SENSOR_W = DEF_SENSOR_W
) ();

    logic                   smp_req;
    logic [SEL_W-1:0]       smp_sel;
    logic                   smp_ack;
    logic [SENSOR_W-1:0]    smp_data;
    logic [SENSOR_W-1:0]    height;
    logic                   height_valid;
    logic                   height_ready;
    logic [NUM_SENSORS-1:0] fault_mask;

    modport master (
        output smp_req,
        output smp_sel,
        input  smp_ack,
        input  smp_data,
        output height,
        output height_valid,
        input  height_ready,
        output fault_mask
    );

    modport slave (
        input  smp_req,
        input  smp_sel,
        output smp_ack,
        output smp_data,
        input  height,
        input  height_valid,
        output height_ready,
        input  fault_mask
    );

endinterface

// File: rtl/sensor_scan_ctrl_height_avg.sv
// Fault-tolerant rounded average of four height readings. A zero reading
// (real or substituted for a silent sensor) knocks out its opposite pair:
// sensors 1/3 and 2/4 are mounted as pairs, so one bad member discards the
// whole pair and the other pair's rounded mean is used instead.
module height_avg
    import sensor_scan_pkg::*;
#(
    parameter int SENSOR_W = DEF_SENSOR_W
) (
    input  logic [SENSOR_W-1:0] i_s1,
    input  logic [SENSOR_W-1:0] i_s2,
    input  logic [SENSOR_W-1:0] i_s3,
    input  logic [SENSOR_W-1:0] i_s4,
    output logic [SENSOR_W-1:0] o_height
);

    logic [SUM_W-1:0] w_sum_24;
    logic [SUM_W-1:0] w_sum_13;
    logic [SUM_W-1:0] w_sum_all;

    // Rounded pair and quad sums, each widened before adding so no carry is lost.
    always_comb begin
        w_sum_24  = SUM_W'(i_s2) + SUM_W'(i_s4) + SUM_W'(1);
        w_sum_13  = SUM_W'(i_s1) + SUM_W'(i_s3) + SUM_W'(1);
        w_sum_all = SUM_W'(i_s1) + SUM_W'(i_s2) + SUM_W'(i_s3) + SUM_W'(i_s4) + SUM_W'(2);
    end

    // Priority selection: pair 1/3 damaged first, then pair 2/4, else all four.
    always_comb begin
        o_height = {SENSOR_W{1'b0}};
        if ((i_s1 == {SENSOR_W{1'b0}}) || (i_s3 == {SENSOR_W{1'b0}})) begin
            o_height = SENSOR_W'(w_sum_24 >> 1);
        end else if ((i_s2 == {SENSOR_W{1'b0}}) || (i_s4 == {SENSOR_W{1'b0}})) begin
            o_height = SENSOR_W'(w_sum_13 >> 1);
        end else begin
            o_height = SENSOR_W'(w_sum_all >> 2);
        end
    end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Scan sequencer: polls the four height sensors one by one over the shared
// sample bus, substitutes 0 for a sensor that stays silent for TIMEOUT
// cycles, reduces the readings to one height and offers it downstream.
module sensor_scan_ctrl
    import sensor_scan_pkg::*;
#(
    parameter int SENSOR_W = DEF_SENSOR_W,
    parameter int TIMEOUT  = 16,
    parameter int TO_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    sensor_scan_ctrl_if.master      bus
);

    localparam logic [TO_W-1:0]  CNT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SENSORS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL_W-1:0]       r_sel;
    logic [SEL_W-1:0]       w_sel_nxt;
    logic [TO_W-1:0]        r_cnt;
    logic [TO_W-1:0]        w_cnt_nxt;
    logic                   w_step;
    logic                   w_tout;

    logic [SENSOR_W-1:0]    r_sample [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] r_fault_work;
    logic [SENSOR_W-1:0]    w_avg;

    logic                   r_smp_req;
    logic                   r_busy;
    logic [SENSOR_W-1:0]    r_height;
    logic                   r_height_valid;
    logic [NUM_SENSORS-1:0] r_fault_mask;

    height_avg #(
        .SENSOR_W (SENSOR_W)
    ) u_height_avg (
        .i_s1     (r_sample[0]),
        .i_s2     (r_sample[1]),
        .i_s3     (r_sample[2]),
        .i_s4     (r_sample[3]),
        .o_height (w_avg)
    );

    // Next-state, sensor select and timeout counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = REQ;
                    w_sel_nxt   = {SEL_W{1'b0}};
                    w_cnt_nxt   = {TO_W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (bus.smp_ack) begin
                    w_step    = 1'b1;
                    w_cnt_nxt = {TO_W{1'b0}};
                end else if (r_cnt == CNT_LAST) begin
                    w_step    = 1'b1;
                    w_tout    = 1'b1;
                    w_cnt_nxt = {TO_W{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
                if (w_step) begin
                    if (r_sel == SEL_LAST) begin
                        w_state_nxt = CALC;
                        w_sel_nxt   = {SEL_W{1'b0}};
                    end else begin
                        w_sel_nxt   = r_sel + SEL_W'(1);
                    end
                end else begin
                    w_state_nxt = REQ;
                end
            end
            CALC: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                if (r_height_valid && bus.height_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = OUT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = {SEL_W{1'b0}};
                w_cnt_nxt   = {TO_W{1'b0}};
            end
        endcase
    end

    // State, select and timeout counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= {SEL_W{1'b0}};
            r_cnt   <= {TO_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Per-sensor sample capture and working fault bits for the current scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                r_sample[i] <= {SENSOR_W{1'b0}};
            end
            r_fault_work <= {NUM_SENSORS{1'b0}};
        end else if ((r_state == REQ) && w_step) begin
            r_sample[r_sel]     <= w_tout ? {SENSOR_W{1'b0}} : bus.smp_data;
            r_fault_work[r_sel] <= w_tout;
        end else begin
            r_fault_work <= r_fault_work;
        end
    end

    // Result registers: height and fault mask change only in CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_height     <= {SENSOR_W{1'b0}};
            r_fault_mask <= {NUM_SENSORS{1'b0}};
        end else if (r_state == CALC) begin
            r_height     <= w_avg;
            r_fault_mask <= r_fault_work;
        end else begin
            r_height     <= r_height;
            r_fault_mask <= r_fault_mask;
        end
    end

    // Registered status outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_req      <= 1'b0;
            r_busy         <= 1'b0;
            r_height_valid <= 1'b0;
        end else begin
            r_smp_req      <= (w_state_nxt == REQ);
            r_busy         <= (w_state_nxt != IDLE);
            r_height_valid <= (w_state_nxt == OUT);
        end
    end

    assign busy             = r_busy;
    assign bus.smp_req      = r_smp_req;
    assign bus.smp_sel      = r_sel;
    assign bus.height       = r_height;
    assign bus.height_valid = r_height_valid;
    assign bus.fault_mask   = r_fault_mask;

endmodule
